// File: rtl/bin_to_therm_pkg.sv
// Shared sizing helpers and mode encoding for the binary-to-thermometer DWA decoder.
//   therm_len(n) : number of unit elements driven by an n-bit code (2**n-1)
//   ptr_width(n) : bits needed to hold a rotation pointer 0..therm_len(n)-1 (min 1)
//   therm_mode_e : per-beat decode mode
package bin_to_therm_pkg;

    function automatic int unsigned therm_len(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned n);
        int unsigned l;
        int unsigned w;
        l = therm_len(n);
        w = 1;
        while ((32'd1 << w) < l) w++;
        return w;
    endfunction

    typedef enum logic {
        MODE_THERM = 1'b0,
        MODE_DWA   = 1'b1
    } therm_mode_e;

endpackage

// File: rtl/dwa_chan.sv
// One decoder channel: combinational rotated-mask decode plus the rotation pointer register.
//   clk, rst_n   : clock, async active-low reset
//   i_k          : binary code 0..L
//   i_accept     : beat accepted this cycle (pointer may advance)
//   i_mode_dwa   : 1 = rotate from pointer, 0 = pack from LSB
//   i_enable     : 0 = all-zero decode, pointer frozen
//   i_ptr_clr    : pointer to 0; a coincident beat decodes with pointer 0
//   o_therm_c    : combinational decode for the current beat
//   o_ptr        : registered pointer
module dwa_chan
    import bin_to_therm_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0]               i_k,
    input  logic                       i_accept,
    input  logic                       i_mode_dwa,
    input  logic                       i_enable,
    input  logic                       i_ptr_clr,
    output logic [therm_len(N)-1:0]    o_therm_c,
    output logic [ptr_width(N)-1:0]    o_ptr
);

    localparam int unsigned L  = therm_len(N);
    localparam int unsigned PW = ptr_width(N);
    localparam int unsigned SW = PW + 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_p;
    logic [PW-1:0] w_p_adv;
    logic [SW-1:0] w_sum;
    logic          w_dwa;

    // A clear coincident with a beat makes that beat decode from element 0.
    assign w_p     = i_ptr_clr ? '0 : r_ptr;
    assign w_dwa   = (therm_mode_e'(i_mode_dwa) == MODE_DWA);
    assign w_sum   = SW'(w_p) + SW'(i_k);
    assign w_p_adv = (w_sum >= SW'(L)) ? PW'(w_sum - SW'(L)) : PW'(w_sum);

    // Bit i is on when its distance above the pointer (mod L) is below k.
    for (genvar gi = 0; gi < int'(L); gi++) begin : g_bit
        logic [SW-1:0] w_idx;
        logic [SW-1:0] w_dist;
        logic [SW-1:0] w_pos;
        assign w_idx  = SW'(gi);
        assign w_dist = (w_idx >= SW'(w_p)) ? (w_idx - SW'(w_p))
                                            : (w_idx + SW'(L) - SW'(w_p));
        assign w_pos  = w_dwa ? w_dist : w_idx;
        assign o_therm_c[gi] = i_enable && (w_pos < SW'(i_k));
    end

    // Pointer advances only on accepted enabled DWA beats; a clear wins otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_accept && i_enable && w_dwa) begin
            r_ptr <= w_p_adv;
        end else if (i_ptr_clr) begin
            r_ptr <= '0;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/bin_to_therm_dec_dwa.sv
// Multi-channel registered binary-to-thermometer decoder with optional DWA rotation.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : input handshake (in_ready combinational, no skid)
//   bin_in               : NCH packed N-bit codes
//   mode_dwa, enable     : shared per-beat controls
//   ptr_clr              : clear all rotation pointers
//   out_valid / out_ready: output handshake
//   therm_out            : NCH packed L-bit thermometer codes (registered)
//   ptr_out              : NCH packed rotation pointers (registered)
module bin_to_therm_dec_dwa
    import bin_to_therm_pkg::*;
#(
    parameter int unsigned N   = 3,
    parameter int unsigned NCH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NCH*N-1:0]               bin_in,
    input  logic                           mode_dwa,
    input  logic                           enable,
    input  logic                           ptr_clr,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NCH*therm_len(N)-1:0]    therm_out,
    output logic [NCH*ptr_width(N)-1:0]    ptr_out
);

    localparam int unsigned L  = therm_len(N);
    localparam int unsigned PW = ptr_width(N);

    logic               r_out_valid;
    logic [NCH*L-1:0]   r_therm;
    logic [NCH*L-1:0]   w_therm;
    logic               w_accept;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    for (genvar gc = 0; gc < int'(NCH); gc++) begin : g_chan
        dwa_chan #(
            .N (N)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_k        (bin_in[gc*N +: N]),
            .i_accept   (w_accept),
            .i_mode_dwa (mode_dwa),
            .i_enable   (enable),
            .i_ptr_clr  (ptr_clr),
            .o_therm_c  (w_therm[gc*L +: L]),
            .o_ptr      (ptr_out[gc*PW +: PW])
        );
    end

    // Single output stage: load on accept, drop valid once consumed, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_therm     <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_therm     <= w_therm;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign therm_out = r_therm;

endmodule

// File: tb/tb_bin_to_therm_dec_dwa.sv
module tb_bin_to_therm_dec_dwa;

    localparam int N   = 3;
    localparam int NCH = 2;
    localparam int L   = 7;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [NCH*N-1:0] bin_in;
    logic             mode_dwa;
    logic             enable;
    logic             ptr_clr;
    logic             out_valid;
    logic             out_ready;
    logic [NCH*L-1:0] therm_out;
    logic [NCH*N-1:0] ptr_out;

    int n_vec = 0;
    int n_err = 0;

    logic [NCH*L-1:0] sb_q[$];
    logic [2:0]       mp[2];
    logic             mv;

    bin_to_therm_dec_dwa #(.N(N), .NCH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .mode_dwa  (mode_dwa),
        .enable    (enable),
        .ptr_clr   (ptr_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .therm_out (therm_out),
        .ptr_out   (ptr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode: lay k ones starting at element p, wrapping at L.
    function automatic logic [L-1:0] ref_therm(input int p, input int k);
        logic [L-1:0] v;
        v = '0;
        for (int j = 0; j < k; j++) v[(p + j) % L] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        sb_q.delete();
        mp[0] = 3'd0;
        mp[1] = 3'd0;
        mv = 1'b0;
    endtask

    // One clock cycle: drive, check pre-edge outputs, advance model, check pointers post-edge.
    task automatic cyc(input logic v, input int k0, input int k1, input logic dwa,
                       input logic en, input logic clr, input logic ordy);
        logic             acc;
        logic [NCH*L-1:0] exp_t;
        int               ks[2];
        int               p;
        in_valid  = v;
        bin_in    = {3'(k1), 3'(k0)};
        mode_dwa  = dwa;
        enable    = en;
        ptr_clr   = clr;
        out_ready = ordy;
        #3;
        chk("in_ready", 32'(in_ready), 32'(!mv || ordy));
        chk("out_valid", 32'(out_valid), 32'(mv));
        if (mv) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'(sb_q.size()), 32'd1);
            end else begin
                chk("sb_therm", 32'(therm_out), 32'(sb_q[0]));
                if (ordy) void'(sb_q.pop_front());
            end
        end
        acc = v && (!mv || ordy);
        ks[0] = k0;
        ks[1] = k1;
        exp_t = '0;
        for (int c = 0; c < NCH; c++) begin
            p = clr ? 0 : int'(mp[c]);
            if (acc && en) exp_t[c*L +: L] = ref_therm(dwa ? p : 0, ks[c]);
            if (acc && en && dwa) mp[c] = 3'((p + ks[c]) % L);
            else                  mp[c] = 3'(p);
        end
        if (acc) sb_q.push_back(exp_t);
        mv = acc ? 1'b1 : (ordy ? 1'b0 : mv);
        @(posedge clk);
        #1;
        chk("ptr_out", 32'(ptr_out), 32'({mp[1], mp[0]}));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        bin_in    = '0;
        mode_dwa  = 1'b0;
        enable    = 1'b0;
        ptr_clr   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_therm", 32'(therm_out), 32'd0);
        chk("rst_ptr", 32'(ptr_out), 32'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // plain thermometer
        cyc(1'b1, 3, 7, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("plain", 32'(therm_out), 32'({7'b1111111, 7'b0000111}));
        chk("plain_ptr", 32'(ptr_out), 32'd0);

        // DWA sequences
        cyc(1'b1, 3, 4, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("dwa1", 32'(therm_out), 32'({7'b0001111, 7'b0000111}));
        chk("dwa1_ptr", 32'(ptr_out), 32'({3'd4, 3'd3}));
        cyc(1'b1, 5, 4, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("dwa2", 32'(therm_out), 32'({7'b1110001, 7'b1111001}));
        chk("dwa2_ptr", 32'(ptr_out), 32'({3'd1, 3'd1}));
        cyc(1'b1, 0, 4, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("dwa3", 32'(therm_out), 32'({7'b0011110, 7'b0000000}));
        chk("dwa3_ptr", 32'(ptr_out), 32'({3'd5, 3'd1}));

        // stall three cycles, then release
        for (int s = 0; s < 3; s++) begin
            cyc(1'b1, 2, 2, 1'b1, 1'b1, 1'b0, 1'b0);
            chk("stall_hold", 32'(therm_out), 32'({7'b0011110, 7'b0000000}));
            chk("stall_ptr", 32'(ptr_out), 32'({3'd5, 3'd1}));
        end
        cyc(1'b1, 2, 2, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("release", 32'(therm_out), 32'({7'b1100000, 7'b0000110}));
        chk("release_ptr", 32'(ptr_out), 32'({3'd0, 3'd3}));

        // enable=0 in DWA mode
        cyc(1'b1, 5, 5, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("disabled", 32'(therm_out), 32'd0);
        chk("disabled_ptr", 32'(ptr_out), 32'({3'd0, 3'd3}));

        // bring both pointers to 4, then clear coincident with k=2
        cyc(1'b1, 1, 4, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("to_p4", 32'(therm_out), 32'({7'b0001111, 7'b0001000}));
        cyc(1'b1, 2, 2, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_beat", 32'(therm_out), 32'({7'b0000011, 7'b0000011}));
        chk("clr_beat_ptr", 32'(ptr_out), 32'({3'd2, 3'd2}));

        // k=L is all ones with pointer unchanged
        cyc(1'b1, 7, 7, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("full", 32'(therm_out), 32'({7'b1111111, 7'b1111111}));
        chk("full_ptr", 32'(ptr_out), 32'({3'd2, 3'd2}));

        // clear without a beat
        cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_idle_ptr", 32'(ptr_out), 32'd0);

        // mixed traffic with random backpressure
        for (int r = 0; r < 60; r++) begin
            cyc(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 2) != 0));
        end

        // async reset while a beat is stalled
        cyc(1'b1, 3, 3, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_therm", 32'(therm_out), 32'd0);
        chk("async_rst_ptr", 32'(ptr_out), 32'd0);
        model_reset();
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 6, 1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("after_rst", 32'(therm_out), 32'({7'b0000001, 7'b0111111}));
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bin_to_therm_dec_dwa.md
Name: bin_to_therm_dec_dwa

Overview:
- Registered, multi-channel binary-to-thermometer decoder for unit-element DAC arrays.
- Two modes per beat:
  - plain thermometer: ones packed from LSB.
  - DWA (data-weighted averaging): ones start at a per-channel rotating pointer and wrap, for element mismatch shaping.
- Sits between the digital modulator output and the DAC switch drivers.
- One valid/ready register stage.

Parameters:
- N, 3, binary input width per channel.
- NCH, 2, number of independent channels.
- L, 2**N-1, localparam: thermometer width per channel (unit elements).
- PW, N, localparam: pointer width (holds 0..L-1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- bin_in  in  NCH*N  packed binary codes; channel c at [c*N +: N].
- mode_dwa  in  1  sampled with beat; 1=DWA, 0=plain thermometer.
- enable  in  1  sampled with beat; 0 forces zero output and freezes pointers.
- ptr_clr  in  1  synchronous pulse: all pointers to 0.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- therm_out  out  NCH*L  packed thermometer codes; channel c at [c*L +: L].
- ptr_out  out  NCH*PW  current pointer per channel, for debug/verification.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, therm_out=0, all pointers=0, so ptr_out=0.
  - in_ready=1 one cycle after deassertion.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, no skid buffer).
  - Accept = in_valid && in_ready.
  - Output beat = out_valid && out_ready.
- Latency: 1 cycle. A beat accepted at edge t appears on therm_out with out_valid=1 after edge t.
- Output hold: therm_out and out_valid hold stable while out_valid && !out_ready.
- Full throughput: one beat per cycle when out_ready=1.
- Per channel c, with k=bin_in[c] (0..L) and p=pointer[c] at accept:
  - enable=0: out=0; pointer unchanged.
  - enable=1, mode_dwa=0: out bit i = (i < k); pointer unchanged.
  - enable=1, mode_dwa=1: out bit i = (((i - p) mod L) < k); pointer <= (p + k) mod L.
- Pointer arithmetic:
  - Use PW+1-bit sum, subtract L if sum >= L.
  - k=L gives all ones and leaves the pointer unchanged.
  - k=0 gives all zeros and leaves the pointer unchanged.
- ptr_clr:
  - Without accept: pointers <= 0 at the next edge.
  - Coincident with an accepted DWA beat: the beat decodes with p=0 and pointer <= k.
- ptr_clr is independent of enable and of the handshake.
- Pointers update only on accepted beats (or ptr_clr), never while stalled.
- Channels are fully independent; the handshake, mode_dwa and enable are shared.
- Reset mid-stream: the pending output beat is discarded; no partial state survives.
- No FSM beyond the output-valid flag. Pointers are NCH registers of PW bits.

Decomposition:
- Package bin_to_therm_pkg:
  - function therm_len(n) = 2**n-1.
  - function clog2-style pointer width.
  - typedef enum {MODE_THERM, MODE_DWA} therm_mode_e.
- Sub-module dwa_chan:
  - One channel: combinational rotate-mask decode plus pointer register with clear/advance.
  - Instantiated NCH times via generate.
  - The top level owns the handshake and the output register.

Test Plan (N=3, L=7, NCH=2):
- Reset then plain mode, ch0 k=3, ch1 k=7 -> after 1 cycle therm_out ch0=7'b0000111, ch1=7'b1111111; ptr_out both 0.
- DWA, ch0 sequence k=3 then k=5 from p=0 -> 7'b0000111 (p->3), then 7'b1111001 (p->1).
- DWA sequence k=4,4,4 on ch1 -> 7'b0001111 (p=4), 7'b1110001 (p=1), 7'b0011110 (p=5). The pointer wrap is correct.
- Hold out_ready=0 for 3 cycles with in_valid=1:
  - in_ready=0 while stalled; therm_out is stable; pointers do not advance.
  - On release, the next beat decodes with the unchanged pointer.
- enable=0 beat with k=5 in DWA mode -> output 0 and pointer unchanged. ptr_clr coincident with DWA k=2 at p=4 -> output 7'b0000011, pointer=2.
- Assert rst_n=0 asynchronously while out_valid=1 mid-stall -> out_valid, therm_out and ptr_out go to 0 immediately, without waiting for a clock edge.
